conv_kmem_rd_gen: RTL and testbench

Parametrised read-address generator for convolution-layer kernel weight memories. Drives NPORTS parallel read addresses into a shared weight ROM. Walks every tap of a kernel, repeats each kernel pass REPS times, then steps to the next kernel group. Uses a start/done and valid/ready handshake toward the convolution datapath, which can stall it. Sits between the layer controller and the weight memory, one instance per convolution layer.

---
 rtl/conv_kmem_rd_gen.sv | 189 ++++++++++++++++++
 tb/tb_conv_kmem_rd_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_kmem_rd_gen.sv
// conv_kmem_rd_gen: read-address generator for convolution kernel weight ROMs.
// Walks every tap of a kernel group REPS times, then steps to the next group,
// producing NPORTS parallel addresses per beat under a valid/ready handshake.
// Optional feature macro: CONV_KMEM_RDLAT_EN adds rd_valid/rd_last (one-cycle
// delayed accept markers for a synchronous ROM) and delays done by one cycle.
module conv_kmem_rd_gen #(
    parameter int KSIZE       = 25,
    parameter int NGROUPS     = 3,
    parameter int REPS        = 64,
    parameter int NPORTS      = 2,
    parameter int PORT_STRIDE = 75,
    parameter int ADDR_W      = 8
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic                                                start,
    input  logic                                                abort,
    input  logic                                                ready,
    output logic [NPORTS*ADDR_W-1:0]                            addr,
    output logic                                                addr_valid,
    output logic                                                tap_last,
    output logic [((NGROUPS > 1) ? $clog2(NGROUPS) : 1)-1:0]    grp_idx,
    output logic                                                busy,
    output logic                                                done
`ifdef CONV_KMEM_RDLAT_EN
    ,
    output logic                                                rd_valid,
    output logic                                                rd_last
`endif
);

    localparam int TW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam int RW = (REPS > 1) ? $clog2(REPS) : 1;
    localparam int GW = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int MAX_ADDR = NGROUPS * KSIZE - 1 + (NPORTS - 1) * PORT_STRIDE;

    // The highest address any port can reach must fit in ADDR_W bits.
    if (MAX_ADDR >= (32'd1 << ADDR_W)) begin : g_addr_range_chk
        $fatal(1, "conv_kmem_rd_gen: address range exceeds ADDR_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   state_r, state_s;
    logic [TW-1:0]            tap_r, tap_s;
    logic [RW-1:0]            rep_r, rep_s;
    logic [GW-1:0]            grp_r, grp_s;
    logic [ADDR_W-1:0]        base_r, base_s;
    logic                     accept_s, final_s, run_s;
    logic [NPORTS*ADDR_W-1:0] addr_r, addr_s;
    logic                     addr_valid_r, tap_last_r, tap_last_s, busy_r, done_r, done_s;
    logic [GW-1:0]            grp_idx_r, grp_idx_s;
`ifdef CONV_KMEM_RDLAT_EN
    logic                     rd_valid_r, rd_valid_s, rd_last_r, rd_last_s;
`endif

    // Next-state and counter advance; counters only move on an accepted beat.
    always_comb begin
        state_s  = state_r;
        tap_s    = tap_r;
        rep_s    = rep_r;
        grp_s    = grp_r;
        base_s   = base_r;
        accept_s = addr_valid_r & ready;
        final_s  = (tap_r == TW'(KSIZE - 1)) && (rep_r == RW'(REPS - 1)) &&
                   (grp_r == GW'(NGROUPS - 1));
        case (state_r)
            ST_IDLE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort || (accept_s && final_s)) begin
                    state_s = abort ? ST_IDLE : ST_DONE;
                    tap_s   = '0;
                    rep_s   = '0;
                    grp_s   = '0;
                    base_s  = '0;
                end else if (accept_s) begin
                    if (tap_r == TW'(KSIZE - 1)) begin
                        tap_s = '0;
                        if (rep_r == RW'(REPS - 1)) begin
                            rep_s  = '0;
                            grp_s  = grp_r + GW'(1'b1);
                            base_s = base_r + ADDR_W'(KSIZE);
                        end else begin
                            rep_s = rep_r + RW'(1'b1);
                        end
                    end else begin
                        tap_s = tap_r + TW'(1'b1);
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                tap_s   = '0;
                rep_s   = '0;
                grp_s   = '0;
                base_s  = '0;
            end
        endcase
    end

    // Output values for the coming cycle, computed from the next-state counters.
    always_comb begin
        run_s      = (state_s == ST_RUN);
        addr_s     = '0;
        tap_last_s = run_s && (tap_s == TW'(KSIZE - 1));
        grp_idx_s  = run_s ? grp_s : '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (run_s) begin
                addr_s[p*ADDR_W +: ADDR_W] = base_s + ADDR_W'(tap_s) + ADDR_W'(p * PORT_STRIDE);
            end else begin
                addr_s[p*ADDR_W +: ADDR_W] = '0;
            end
        end
`ifdef CONV_KMEM_RDLAT_EN
        // done trails the DONE state so it lands after the last ROM read beat.
        done_s     = (state_r == ST_DONE) && !abort;
        rd_valid_s = accept_s && !abort;
        rd_last_s  = accept_s && tap_last_r && !abort;
`else
        done_s     = (state_s == ST_DONE);
`endif
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            tap_r        <= '0;
            rep_r        <= '0;
            grp_r        <= '0;
            base_r       <= '0;
            addr_r       <= '0;
            addr_valid_r <= 1'b0;
            tap_last_r   <= 1'b0;
            grp_idx_r    <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
`ifdef CONV_KMEM_RDLAT_EN
            rd_valid_r   <= 1'b0;
            rd_last_r    <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            tap_r        <= tap_s;
            rep_r        <= rep_s;
            grp_r        <= grp_s;
            base_r       <= base_s;
            addr_r       <= addr_s;
            addr_valid_r <= run_s;
            tap_last_r   <= tap_last_s;
            grp_idx_r    <= grp_idx_s;
            busy_r       <= run_s;
            done_r       <= done_s;
`ifdef CONV_KMEM_RDLAT_EN
            rd_valid_r   <= rd_valid_s;
            rd_last_r    <= rd_last_s;
`endif
        end
    end

    assign addr       = addr_r;
    assign addr_valid = addr_valid_r;
    assign tap_last   = tap_last_r;
    assign grp_idx    = grp_idx_r;
    assign busy       = busy_r;
    assign done       = done_r;
`ifdef CONV_KMEM_RDLAT_EN
    assign rd_valid   = rd_valid_r;
    assign rd_last    = rd_last_r;
`endif

endmodule

// File: tb/tb_conv_kmem_rd_gen.sv
// Self-checking bench for conv_kmem_rd_gen: default-parameter instance checked
// cycle by cycle against a beat-index model, plus a small alternate-parameter
// instance checked against closed-form addresses.
module tb_conv_kmem_rd_gen;
    localparam int K = 25, G = 3, R = 64, P = 2, S = 75, AW = 8;
    localparam int TOTAL = K * R * G;

    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b0;
    logic [P*AW-1:0] addr;
    logic addr_valid, tap_last, busy, done;
    logic [1:0] grp_idx;
    logic start2 = 1'b0;
    logic [3*AW-1:0] addr2;
    logic addr_valid2, tap_last2, busy2, done2;
    logic [1:0] grp_idx2;
`ifdef CONV_KMEM_RDLAT_EN
    logic rd_valid, rd_last, rd_valid2, rd_last2;
`endif

    conv_kmem_rd_gen dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .ready(ready),
        .addr(addr), .addr_valid(addr_valid), .tap_last(tap_last), .grp_idx(grp_idx),
        .busy(busy), .done(done)
`ifdef CONV_KMEM_RDLAT_EN
        , .rd_valid(rd_valid), .rd_last(rd_last)
`endif
    );

    conv_kmem_rd_gen #(.KSIZE(9), .NGROUPS(4), .REPS(2), .NPORTS(3), .PORT_STRIDE(36), .ADDR_W(8)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .abort(1'b0), .ready(1'b1),
        .addr(addr2), .addr_valid(addr_valid2), .tap_last(tap_last2), .grp_idx(grp_idx2),
        .busy(busy2), .done(done2)
`ifdef CONV_KMEM_RDLAT_EN
        , .rd_valid(rd_valid2), .rd_last(rd_last2)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int acc_cnt = 0, tl_cnt = 0, done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: the walk is a single beat index n; everything else is arithmetic on n.
    function automatic int exp_addr(input int n, input int p);
        return (n / (K * R)) * K + (n % K) + p * S;
    endfunction

    bit m_active = 1'b0, m_in_done = 1'b0, m_done = 1'b0, m_rdv = 1'b0, m_rdl = 1'b0;
    int m_beat = 0;
    bit o_active, o_in_done, o_acc;
    int o_beat;

    // Model update at each edge, then compare all outputs just after it.
    always @(posedge clk) begin
        if (reset_n) begin
            if (addr_valid && ready) begin
                acc_cnt++;
                if (tap_last) tl_cnt++;
            end
            if (done) done_cnt++;
        end
        if (!reset_n) begin
            m_active = 1'b0; m_in_done = 1'b0; m_done = 1'b0; m_rdv = 1'b0; m_rdl = 1'b0; m_beat = 0;
        end else begin
            o_active = m_active; o_in_done = m_in_done; o_beat = m_beat;
            o_acc = o_active && ready;
            if (abort) begin
                m_active = 1'b0; m_in_done = 1'b0; m_beat = 0;
            end else if (o_active) begin
                if (ready) begin
                    if (o_beat == TOTAL - 1) begin
                        m_active = 1'b0; m_in_done = 1'b1; m_beat = 0;
                    end else begin
                        m_beat = o_beat + 1;
                    end
                end
            end else if (o_in_done) begin
                m_in_done = 1'b0;
            end else if (start) begin
                m_active = 1'b1; m_beat = 0;
            end
`ifdef CONV_KMEM_RDLAT_EN
            m_rdv  = o_acc && !abort;
            m_rdl  = m_rdv && (o_beat % K == K - 1);
            m_done = o_in_done && !abort;
`else
            m_done = m_in_done;
`endif
        end
        #1;
        if (reset_n) begin
            chk("addr_valid", int'(addr_valid), int'(m_active));
            chk("busy", int'(busy), int'(m_active));
            chk("done", int'(done), int'(m_done));
            if (m_active) begin
                for (int p = 0; p < P; p++) chk("addr_port", int'(addr[p*AW +: AW]), exp_addr(m_beat, p));
                chk("tap_last", int'(tap_last), int'(m_beat % K == K - 1));
                chk("grp_idx", int'(grp_idx), m_beat / (K * R));
            end else begin
                chk("tap_last_idle", int'(tap_last), 0);
            end
`ifdef CONV_KMEM_RDLAT_EN
            chk("rd_valid", int'(rd_valid), int'(m_rdv));
            chk("rd_last", int'(rd_last), int'(m_rdl));
`endif
        end
    end

    task automatic clear_counts();
        acc_cnt = 0; tl_cnt = 0; done_cnt = 0;
    endtask

    int cyc, cnt2, d2, a;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_addr", int'(addr), 0);
        chk("rst_valid", int'(addr_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_grp", int'(grp_idx), 0);
        chk("rst_tap_last", int'(tap_last), 0);
        reset_n = 1'b1;

        // Full walk with ready tied high
        @(negedge clk); clear_counts(); ready = 1'b1; start = 1'b1;
        for (int i = 0; i < TOTAL; i++) begin
            @(posedge clk); #1; start = 1'b0;
            if (i == 0)    begin chk("first_p0", int'(addr[7:0]), 0);   chk("first_p1", int'(addr[15:8]), 75); end
            if (i == 24)   begin chk("tap24_last", int'(tap_last), 1);  chk("tap24_p0", int'(addr[7:0]), 24); end
            if (i == 1600) begin chk("g1_p0", int'(addr[7:0]), 25);     chk("g1_p1", int'(addr[15:8]), 100); chk("g1_idx", int'(grp_idx), 1); end
            if (i == 4799) begin chk("last_p0", int'(addr[7:0]), 74);   chk("last_p1", int'(addr[15:8]), 149); chk("last_grp", int'(grp_idx), 2); end
        end
        @(posedge clk); #1;
        chk("end_valid", int'(addr_valid), 0);
        chk("end_busy", int'(busy), 0);
`ifdef CONV_KMEM_RDLAT_EN
        chk("done_m1", int'(done), 0);
        @(posedge clk); #1; chk("done_m2", int'(done), 1);
`else
        chk("done_m1", int'(done), 1);
        @(posedge clk); #1; chk("done_m2", int'(done), 0);
`endif
        repeat (3) @(posedge clk); #1;
        chk("t1_beats", acc_cnt, TOTAL);
        chk("t1_taplast", tl_cnt, 192);
        chk("t1_done_cnt", done_cnt, 1);

        // Random ready, stray start pulses while running
        @(negedge clk); clear_counts(); start = 1'b1; ready = 1'b0;
        cyc = 0;
        @(posedge clk); #1;
        while (!m_done && cyc < 30000) begin
            @(negedge clk); ready = 1'($urandom_range(1)); start = ($urandom_range(15) == 0);
            @(posedge clk); #1; cyc++;
        end
        chk("t2_timeout", int'(cyc >= 30000), 0);
        @(negedge clk); start = 1'b0; ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("t2_beats", acc_cnt, TOTAL);
        chk("t2_taplast", tl_cnt, 192);
        chk("t2_done_cnt", done_cnt, 1);

        // Reset mid-walk
        @(negedge clk); start = 1'b1; ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (1000) @(posedge clk);
        @(negedge clk); reset_n = 1'b0; #1;
        chk("mid_rst_addr", int'(addr), 0);
        chk("mid_rst_valid", int'(addr_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_grp", int'(grp_idx), 0);
        chk("mid_rst_tap_last", int'(tap_last), 0);
        chk("mid_rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("restart_p0", int'(addr[7:0]), 0);
        chk("restart_p1", int'(addr[15:8]), 75);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("abort1_valid", int'(addr_valid), 0);

        // Abort at group 1, rep 10 with a simultaneous start
        @(negedge clk); clear_counts(); start = 1'b1;
        for (int i = 0; i <= 1850; i++) begin
            @(posedge clk); #1; start = 1'b0;
        end
        chk("ab_grp", int'(grp_idx), 1);
        chk("ab_p0", int'(addr[7:0]), 25);
        @(negedge clk); abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        chk("ab_valid", int'(addr_valid), 0);
        chk("ab_busy", int'(busy), 0);
        @(negedge clk); abort = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("ab_no_done", done_cnt, 0);
        chk("ab_idle", int'(busy), 0);
        // start and abort together in IDLE
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        chk("sa_idle_valid", int'(addr_valid), 0);
        @(negedge clk); start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        chk("sa_idle_busy", int'(busy), 0);

        // Alternate parameters: K=9, G=4, R=2, 3 ports, stride 36
        @(negedge clk); start2 = 1'b1; cnt2 = 0; d2 = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1; start2 = 1'b0;
            if (done2) d2++;
            if (addr_valid2) begin
                a = (cnt2 / 18) * 9 + cnt2 % 9;
                for (int p = 0; p < 3; p++) chk("p2_addr", int'(addr2[p*AW +: AW]), a + 36 * p);
                if (cnt2 == 71) begin
                    chk("p2_last0", int'(addr2[7:0]), 35);
                    chk("p2_last1", int'(addr2[15:8]), 71);
                    chk("p2_last2", int'(addr2[23:16]), 107);
                    chk("p2_tap_last", int'(tap_last2), 1);
                end
                cnt2++;
            end
        end
        chk("p2_beats", cnt2, 72);
        chk("p2_done", d2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
